// File: rtl/bcd_cascade_scan_if.sv
// Bus between the upstream decade counter / display driver and bcd_cascade_scan.
`timescale 1ns/1ps
interface bcd_cascade_scan_if;
    logic [3:0] units_in;
    logic       clear;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic       carry_out;
    logic       code_err;
    logic [6:0] seg;
    logic [2:0] an;

    modport master (
        output units_in, clear,
        input  tens, hundreds, carry_out, code_err, seg, an
    );

    modport slave (
        input  units_in, clear,
        output tens, hundreds, carry_out, code_err, seg, an
    );
endinterface

// File: rtl/bcd_cascade_scan.sv
// Cascades the upstream units wrap into tens/hundreds BCD digits and scans
// all three digits onto a shared 7-segment bus.
// Optional macro BCD_CASCADE_SATURATE_EN: hold the count at 99x instead of
// wrapping 999->000, pulsing carry_out only on the first saturating wrap.
`timescale 1ns/1ps
module bcd_cascade_scan #(
    parameter int unsigned SCAN_DIV = 4
) (
    input logic             clk,
    input logic             reset,
    bcd_cascade_scan_if.slave bus
);
    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        SEL_UNITS    = 2'd0,
        SEL_TENS     = 2'd1,
        SEL_HUNDREDS = 2'd2
    } digit_sel_t;

    logic [3:0]       prev_units;
    logic [3:0]       tens_q;
    logic [3:0]       hundreds_q;
    logic             carry_q;
    logic             err_q;
    logic             wrap_c;
    logic [CNT_W-1:0] scan_cnt;
    logic [CNT_W-1:0] scan_cnt_next;
    digit_sel_t       sel_q;
    digit_sel_t       sel_next;
    logic [3:0]       digit_c;
    logic [2:0]       an_c;
    logic [6:0]       seg_q;
    logic [2:0]       an_q;
`ifdef BCD_CASCADE_SATURATE_EN
    logic             sat_done;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Illegal codes never equal 9 or 0, so they cannot take part in a wrap.
    assign wrap_c = (prev_units == 4'd9) && (bus.units_in == 4'd0);

    // Units history, tens/hundreds cascade, carry pulse and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_units <= 4'd0;
            tens_q     <= 4'd0;
            hundreds_q <= 4'd0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef BCD_CASCADE_SATURATE_EN
            sat_done   <= 1'b0;
`endif
        end else begin
            prev_units <= bus.units_in;
            if (bus.clear) begin
                tens_q     <= 4'd0;
                hundreds_q <= 4'd0;
                carry_q    <= 1'b0;
                err_q      <= 1'b0;
`ifdef BCD_CASCADE_SATURATE_EN
                sat_done   <= 1'b0;
`endif
            end else begin
                carry_q <= 1'b0;
                if (bus.units_in > 4'd9) begin
                    err_q <= 1'b1;
                end
                if (wrap_c) begin
                    if (tens_q != 4'd9) begin
                        tens_q <= tens_q + 4'd1;
                    end else if (hundreds_q != 4'd9) begin
                        tens_q     <= 4'd0;
                        hundreds_q <= hundreds_q + 4'd1;
                    end else begin
`ifdef BCD_CASCADE_SATURATE_EN
                        if (!sat_done) begin
                            carry_q  <= 1'b1;
                            sat_done <= 1'b1;
                        end
`else
                        tens_q     <= 4'd0;
                        hundreds_q <= 4'd0;
                        carry_q    <= 1'b1;
`endif
                    end
                end
            end
        end
    end

    // Scan state register: dwell counter and selected digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            sel_q    <= SEL_UNITS;
        end else begin
            scan_cnt <= scan_cnt_next;
            sel_q    <= sel_next;
        end
    end

    // Scan next state: advance the digit after SCAN_DIV cycles of dwell.
    always_comb begin
        scan_cnt_next = scan_cnt + CNT_W'(1);
        sel_next      = sel_q;
        if (scan_cnt == SCAN_LAST) begin
            scan_cnt_next = '0;
            case (sel_q)
                SEL_UNITS: sel_next = SEL_TENS;
                SEL_TENS:  sel_next = SEL_HUNDREDS;
                default:   sel_next = SEL_UNITS;
            endcase
        end
    end

    // Current digit value and its active-low anode enable.
    always_comb begin
        digit_c = prev_units;
        an_c    = 3'b110;
        case (sel_q)
            SEL_TENS: begin
                digit_c = tens_q;
                an_c    = 3'b101;
            end
            SEL_HUNDREDS: begin
                digit_c = hundreds_q;
                an_c    = 3'b011;
            end
            default: begin
                digit_c = prev_units;
                an_c    = 3'b110;
            end
        endcase
    end

    // Registered display drive, one cycle behind the selected digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= 7'b0111111;
            an_q  <= 3'b110;
        end else begin
            seg_q <= seg_decode(digit_c);
            an_q  <= an_c;
        end
    end

    assign bus.tens      = tens_q;
    assign bus.hundreds  = hundreds_q;
    assign bus.carry_out = carry_q;
    assign bus.code_err  = err_q;
    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
endmodule
